// File: rtl/vm_pkg.sv
// -----------------------------------------------------------------------------
// vm_pkg
// Shared definitions for the vending-machine change dispenser:
//   - coin_sel encodings (COIN_100 / COIN_500 / COIN_1000)
//   - denomination values in 100-won units (1, 5, 10)
//   - dispenser FSM state enum
//   - denom_of(): coin_sel -> denomination in units
// No ports (package).
// -----------------------------------------------------------------------------
package vm_pkg;

    typedef logic [1:0] coin_sel_t;

    localparam coin_sel_t COIN_100  = 2'd0;
    localparam coin_sel_t COIN_500  = 2'd1;
    localparam coin_sel_t COIN_1000 = 2'd2;

    localparam logic [3:0] DENOM_100  = 4'd1;
    localparam logic [3:0] DENOM_500  = 4'd5;
    localparam logic [3:0] DENOM_1000 = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_DONE   = 2'd3
    } disp_state_t;

    // Encoding 3 is never produced; it maps to the smallest coin so that a
    // corrupted select can never overdraw the balance.
    function automatic logic [3:0] denom_of(input coin_sel_t sel);
        logic [3:0] d;
        case (sel)
            COIN_1000: d = DENOM_1000;
            COIN_500:  d = DENOM_500;
            COIN_100:  d = DENOM_100;
            default:   d = DENOM_100;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
// Groups the refund request, coin handshake and status signals.
//   start/amount      : refund request from the FSM domain
//   coin_valid/ready  : one coin per handshake towards the ejector
//   coin_sel          : 0 = 100, 1 = 500, 2 = 1000
//   busy/done/err     : status back to the FSM
//   remaining         : balance not yet dispensed (100-won units)
// Modports: master = requester/ejector side, slave = the dispenser.
// -----------------------------------------------------------------------------
interface change_dispenser_if #(
    parameter int AMT_W = 7
);
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             coin_ready;
    logic             coin_valid;
    logic [1:0]       coin_sel;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] remaining;
    logic             err;

    modport master (
        output start, amount, coin_ready,
        input  coin_valid, coin_sel, busy, done, remaining, err
    );

    modport slave (
        input  start, amount, coin_ready,
        output coin_valid, coin_sel, busy, done, remaining, err
    );
endinterface

// File: rtl/denom_picker.sv
// -----------------------------------------------------------------------------
// denom_picker
// Purely combinational greedy selector: largest coin not exceeding the
// remaining balance. Also usable by the next-coin display.
// Ports:
//   remaining_i [AMT_W] : balance in 100-won units
//   coin_sel_o  [2]     : COIN_1000 if >=10, COIN_500 if >=5, else COIN_100
//   denom_o     [AMT_W] : value of the selected coin in units
// -----------------------------------------------------------------------------
module denom_picker
    import vm_pkg::*;
#(
    parameter int AMT_W = 7
) (
    input  logic [AMT_W-1:0] remaining_i,
    output logic [1:0]       coin_sel_o,
    output logic [AMT_W-1:0] denom_o
);

    // Greedy choice of the largest denomination that fits.
    always_comb begin
        coin_sel_o = COIN_100;
        if (remaining_i >= AMT_W'(DENOM_1000)) begin
            coin_sel_o = COIN_1000;
        end else if (remaining_i >= AMT_W'(DENOM_500)) begin
            coin_sel_o = COIN_500;
        end else begin
            coin_sel_o = COIN_100;
        end
        denom_o = AMT_W'(denom_of(coin_sel_o));
    end

endmodule

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Pays a refund out greedily (1000, 500, 100) with one coin per valid/ready
// handshake. All outputs are registered.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : change_dispenser_if.slave (start, amount, coin_ready in;
//              coin_valid, coin_sel, busy, done, remaining, err out)
// Optional feature macro: CHANGE_DISPENSER_TIMEOUT_EN
//   defined   -> a coin waiting TIMEOUT_CYC cycles for coin_ready aborts the
//                payout, sets sticky err and pulses done
//   undefined -> err is tied low and ISSUE waits indefinitely
// -----------------------------------------------------------------------------
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W = 7
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    change_dispenser_if.slave  bus
);

    disp_state_t      state_q, state_d;
    logic             coin_valid_q, coin_valid_d;
    logic [1:0]       coin_sel_q, coin_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;

    logic [1:0]       pick_sel_s;
    logic [AMT_W-1:0] pick_denom_s;
    logic [AMT_W-1:0] rem_next_s;
    logic             handshake_s;

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W-1:0] wait_inc_s;
`endif

    denom_picker #(.AMT_W(AMT_W)) u_picker (
        .remaining_i (remaining_q),
        .coin_sel_o  (pick_sel_s),
        .denom_o     (pick_denom_s)
    );

    // remaining is held through ISSUE, so the picker still reflects the
    // coin on offer and can supply the amount to subtract.
    assign handshake_s = coin_valid_q & bus.coin_ready;
    assign rem_next_s  = remaining_q - pick_denom_s;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    assign wait_inc_s  = wait_q + WAIT_W'(1);
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        coin_valid_d = coin_valid_q;
        coin_sel_d   = coin_sel_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        remaining_d  = remaining_q;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        err_d        = err_q;
        wait_d       = wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (bus.amount != {AMT_W{1'b0}}) begin
                        remaining_d = bus.amount;
                        busy_d      = 1'b1;
                        state_d     = ST_SELECT;
                    end else begin
                        // Zero refund: acknowledge without ever going busy.
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                coin_sel_d   = pick_sel_s;
                coin_valid_d = 1'b1;
                state_d      = ST_ISSUE;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
                wait_d       = {WAIT_W{1'b0}};
`endif
            end
            ST_ISSUE: begin
                if (handshake_s) begin
                    remaining_d  = rem_next_s;
                    coin_valid_d = 1'b0;
                    if (rem_next_s == {AMT_W{1'b0}}) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SELECT;
                    end
                end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
                else if (wait_inc_s == WAIT_W'(TIMEOUT_CYC)) begin
                    // Abort: the unaccepted coin stays in remaining.
                    wait_d       = wait_inc_s;
                    coin_valid_d = 1'b0;
                    err_d        = 1'b1;
                    done_d       = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    wait_d = wait_inc_s;
                end
`else
                else begin
                    state_d = ST_ISSUE;
                end
`endif
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                coin_valid_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            coin_valid_q <= 1'b0;
            coin_sel_q   <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            remaining_q  <= {AMT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            coin_valid_q <= coin_valid_d;
            coin_sel_q   <= coin_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            remaining_q  <= remaining_d;
        end
    end

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q  <= 1'b0;
            wait_q <= {WAIT_W{1'b0}};
        end else begin
            err_q  <= err_d;
            wait_q <= wait_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.coin_valid = coin_valid_q;
    assign bus.coin_sel   = coin_sel_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.remaining  = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Scoreboard bench: each accepted refund pushes its greedy coin sequence
// (coin type and balance shown while the coin is offered); a monitor pops and
// compares on every coin handshake. Status behaviour is checked inline.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

    localparam int AMT_W = 7;

    typedef struct {
        logic [1:0]       sel;
        logic [AMT_W-1:0] rem;
    } coin_exp_t;

    logic clk;
    logic reset_n;

    change_dispenser_if #(.AMT_W(AMT_W)) bus ();

    change_dispenser #(.AMT_W(AMT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int        n_checks = 0;
    int        n_errors = 0;
    int        cyc      = 0;
    int        hs_cnt   = 0;
    int        last_hs_cyc = 0;
    int        pay_sum  = 0;
    coin_exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int units_of(input logic [1:0] sel);
        case (sel)
            2'd2:    return 10;
            2'd1:    return 5;
            default: return 1;
        endcase
    endfunction

    // Greedy reference sequence for a refund of amt units.
    task automatic push_payout(input int amt);
        int r;
        coin_exp_t e;
        r = amt;
        while (r > 0) begin
            e.rem = AMT_W'(r);
            if (r >= 10)      begin e.sel = 2'd2; r -= 10; end
            else if (r >= 5)  begin e.sel = 2'd1; r -= 5;  end
            else              begin e.sel = 2'd0; r -= 1;  end
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input int amt);
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.amount = AMT_W'(amt);
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && bus.done !== 1'b1; i++) @(negedge clk);
        check_eq("done_seen", 32'(bus.done), 32'd1);
    endtask

    // Coin handshake monitor: compares each accepted coin with the scoreboard.
    always @(negedge clk) begin
        if (reset_n && bus.coin_valid && bus.coin_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_coin", 32'(exp_q.size()), 32'd1);
            end else begin
                coin_exp_t e;
                e = exp_q.pop_front();
                check_eq("coin_sel", 32'(bus.coin_sel), 32'(e.sel));
                check_eq("coin_rem", 32'(bus.remaining), 32'(e.rem));
            end
            hs_cnt++;
            last_hs_cyc = cyc;
            pay_sum += units_of(bus.coin_sel);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int vcnt;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.amount     = '0;
        bus.coin_ready = 1'b0;

        // Reset state
        #3;
        check_eq("rst_valid", 32'(bus.coin_valid), 32'd0);
        check_eq("rst_sel",   32'(bus.coin_sel),   32'd0);
        check_eq("rst_busy",  32'(bus.busy),       32'd0);
        check_eq("rst_done",  32'(bus.done),       32'd0);
        check_eq("rst_rem",   32'(bus.remaining),  32'd0);
        check_eq("rst_err",   32'(bus.err),        32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // amount=18, ready always high: 1000,500,100,100,100
        bus.coin_ready = 1'b1;
        h = hs_cnt;
        push_payout(18);
        do_start(18);
        @(negedge clk);
        check_eq("s1_busy_select", 32'(bus.busy), 32'd1);
        wait_done(60);
        check_eq("s1_done_lat", 32'(cyc - last_hs_cyc), 32'd1);
        check_eq("s1_busy_at_done", 32'(bus.busy), 32'd1);
        check_eq("s1_rem_end", 32'(bus.remaining), 32'd0);
        check_eq("s1_hs", 32'(hs_cnt - h), 32'd5);
        check_eq("s1_q_empty", 32'(exp_q.size()), 32'd0);
        check_eq("s1_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        check_eq("s1_done_pulse", 32'(bus.done), 32'd0);
        check_eq("s1_busy_after", 32'(bus.busy), 32'd0);

        // amount=0: done one cycle later, never busy or valid
        do_start(0);
        @(negedge clk);
        check_eq("s2_done", 32'(bus.done), 32'd1);
        check_eq("s2_busy", 32'(bus.busy), 32'd0);
        check_eq("s2_valid", 32'(bus.coin_valid), 32'd0);
        @(negedge clk);
        check_eq("s2_done_pulse", 32'(bus.done), 32'd0);
        check_eq("s2_busy2", 32'(bus.busy), 32'd0);
        check_eq("s2_valid2", 32'(bus.coin_valid), 32'd0);

        // amount=7, first coin stalled 5 cycles
        bus.coin_ready = 1'b0;
        push_payout(7);
        do_start(7);
        @(negedge clk);
        check_eq("s3_valid_select", 32'(bus.coin_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("s3_stall_valid", 32'(bus.coin_valid), 32'd1);
            check_eq("s3_stall_sel",   32'(bus.coin_sel),   32'd1);
            check_eq("s3_stall_rem",   32'(bus.remaining),  32'd7);
        end
        @(posedge clk);
        #1 bus.coin_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("s3_rem_after", 32'(bus.remaining), 32'd2);
        wait_done(40);
        check_eq("s3_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        // amount=12, reset after first handshake, then amount=3
        push_payout(12);
        do_start(12);
        for (int i = 0; i < 20 && !(bus.coin_valid && bus.coin_ready); i++) @(negedge clk);
        check_eq("s4_first_hs", 32'(bus.coin_valid && bus.coin_ready), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check_eq("s4_rst_valid", 32'(bus.coin_valid), 32'd0);
        check_eq("s4_rst_busy",  32'(bus.busy),       32'd0);
        check_eq("s4_rst_done",  32'(bus.done),       32'd0);
        check_eq("s4_rst_rem",   32'(bus.remaining),  32'd0);
        check_eq("s4_rst_sel",   32'(bus.coin_sel),   32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("s4_idle_done",  32'(bus.done),       32'd0);
            check_eq("s4_idle_busy",  32'(bus.busy),       32'd0);
            check_eq("s4_idle_valid", 32'(bus.coin_valid), 32'd0);
        end
        h = hs_cnt;
        push_payout(3);
        do_start(3);
        wait_done(40);
        check_eq("s4_hs3", 32'(hs_cnt - h), 32'd3);
        check_eq("s4_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        // amount=15 with an ignored start (amount=4) mid-payout
        h = hs_cnt;
        pay_sum = 0;
        push_payout(15);
        do_start(15);
        repeat (2) @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.amount = AMT_W'(4);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(60);
        check_eq("s5_sum", 32'(pay_sum), 32'd15);
        check_eq("s5_hs", 32'(hs_cnt - h), 32'd2);
        check_eq("s5_rem", 32'(bus.remaining), 32'd0);
        check_eq("s5_q_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("s5_no_restart", 32'(bus.busy), 32'd0);
        end

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        // amount=5, ready held low: abort after 16 waiting cycles
        bus.coin_ready = 1'b0;
        vcnt = 0;
        do_start(5);
        for (int i = 0; i < 100 && bus.done !== 1'b1; i++) begin
            @(negedge clk);
            if (bus.coin_valid) vcnt++;
        end
        check_eq("s6_done", 32'(bus.done), 32'd1);
        check_eq("s6_wait_cycles", 32'(vcnt), 32'd16);
        check_eq("s6_valid", 32'(bus.coin_valid), 32'd0);
        check_eq("s6_err", 32'(bus.err), 32'd1);
        check_eq("s6_rem", 32'(bus.remaining), 32'd5);
        @(negedge clk);
        check_eq("s6_err_sticky", 32'(bus.err), 32'd1);
        bus.coin_ready = 1'b1;
        push_payout(1);
        do_start(1);
        @(negedge clk);
        check_eq("s6_err_clear", 32'(bus.err), 32'd0);
        wait_done(40);
        check_eq("s6_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
`else
        vcnt = 0;
        check_eq("no_timeout_err", 32'(bus.err), 32'(vcnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
